// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - opcode/funct codes shared with the ALU and the decode helper
package decode_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic       legal;
    logic       use_rs;
    logic       use_rt;
    logic       has_dst;
    logic [4:0] dst;
    logic       load;
  } dec_t;

  // Illegal words decode to "uses nothing, writes nothing" so they never stall.
  function automatic dec_t decode_inst(input logic [31:0] inst);
    dec_t d;
    d = '0;
    case (inst[31:26])
      OP_RTYPE: begin
        case (inst[5:0])
          FN_SLL, FN_SRL, FN_SRA: begin
            d.legal  = 1'b1;
            d.use_rt = 1'b1;
          end
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: begin
            d.legal  = 1'b1;
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
          end
          default: d.legal = 1'b0;
        endcase
        if (d.legal) d.dst = inst[15:11];
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
        d.legal  = 1'b1;
        d.use_rs = 1'b1;
        d.dst    = inst[20:16];
        d.load   = (inst[31:26] == OP_LW);
      end
      OP_SW: begin
        d.legal  = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    d.has_dst = (d.dst != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_fwd.sv
// rtl/decode_issue_fwd.sv - operand bypass mux: r0, then EX result, then WB data, then register file
module decode_issue_fwd (
  input  logic [4:0]  src,
  input  logic        ex_we,
  input  logic [4:0]  ex_dst,
  input  logic [31:0] ex_rslt,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] rf_data,
  output logic [31:0] operand
);

  always_comb begin
    operand = rf_data;
    if (src == 5'd0)                      operand = 32'd0;
    else if (ex_we && ex_dst == src)      operand = ex_rslt;
    else if (wb_en && wb_addr == src)     operand = wb_data;
  end

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage with operand forwarding, load/WAW scoreboard interlock and
// a backpressure-held issue register feeding the ALU
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  input  logic [31:0]            if_inst,
  output logic                   if_ready,
  input  logic                   flush,
  output logic [4:0]             rf_ra_rs,
  output logic [4:0]             rf_ra_rt,
  input  logic [31:0]            rf_rd_rs,
  input  logic [31:0]            rf_rd_rt,
  input  logic                   ex_we,
  input  logic [4:0]             ex_dst,
  input  logic [31:0]            ex_rslt,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  input  logic                   ex_ready,
  output logic                   iss_valid,
  output logic [5:0]             opcode,
  output logic [5:0]             funct,
  output logic [4:0]             shamt_in,
  output logic [15:0]            imm,
  output logic [31:0]            rrs,
  output logic [31:0]            rrt_in,
  output logic [4:0]             iss_dst,
  output logic                   iss_we,
  output logic                   iss_load,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  dec_t        dec;
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic        rs_wait;
  logic        rt_wait;
  logic        waw;
  logic        hazard;
  logic        accept;

  assign rf_ra_rs = if_inst[25:21];
  assign rf_ra_rt = if_inst[20:16];

  always_comb dec = decode_inst(if_inst);

  decode_issue_fwd u_fwd_rs (
    .src     (rf_ra_rs),
    .ex_we   (ex_we),
    .ex_dst  (ex_dst),
    .ex_rslt (ex_rslt),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rf_data (rf_rd_rs),
    .operand (fwd_rs)
  );

  decode_issue_fwd u_fwd_rt (
    .src     (rf_ra_rt),
    .ex_we   (ex_we),
    .ex_dst  (ex_dst),
    .ex_rslt (ex_rslt),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rf_data (rf_rd_rt),
    .operand (fwd_rt)
  );

  // A pending source being written back this cycle is already covered by the WB bypass.
  assign rs_wait = dec.use_rs && pending[rf_ra_rs] && !(wb_en && wb_addr == rf_ra_rs);
  assign rt_wait = dec.use_rt && pending[rf_ra_rt] && !(wb_en && wb_addr == rf_ra_rt);
  assign waw     = dec.has_dst && pending[dec.dst];
  assign hazard  = if_valid && (rs_wait || rt_wait || waw);

  assign if_ready = !hazard && !flush && (!iss_valid || ex_ready);
  assign accept   = if_valid && if_ready;

  // Clear first so a same-edge set of the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_addr] = 1'b0;
    if (accept && dec.load && dec.has_dst) pending_nxt[dec.dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && stall_cnt != {STALL_CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_we    <= 1'b0;
      iss_load  <= 1'b0;
      illegal   <= 1'b0;
      opcode    <= '0;
      funct     <= '0;
      shamt_in  <= '0;
      imm       <= '0;
      rrs       <= '0;
      rrt_in    <= '0;
      iss_dst   <= '0;
    end else begin
      illegal <= 1'b0;
      if (flush) begin
        iss_valid <= 1'b0;
        iss_we    <= 1'b0;
        iss_load  <= 1'b0;
      end else if (accept) begin
        iss_valid <= 1'b1;
        iss_we    <= dec.has_dst;
        iss_load  <= dec.load;
        illegal   <= !dec.legal;
        opcode    <= if_inst[31:26];
        funct     <= if_inst[5:0];
        shamt_in  <= if_inst[10:6];
        imm       <= if_inst[15:0];
        rrs       <= fwd_rs;
        rrt_in    <= fwd_rt;
        iss_dst   <= dec.dst;
      end else if (!iss_valid || ex_ready) begin
        iss_valid <= 1'b0;
        iss_we    <= 1'b0;
        iss_load  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - randomized scoreboard bench for decode_issue against a behavioural model
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        flush;
  logic [4:0]  rf_ra_rs, rf_ra_rt;
  logic [31:0] rf_rd_rs, rf_rd_rt;
  logic        ex_we;
  logic [4:0]  ex_dst;
  logic [31:0] ex_rslt;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        iss_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt_in;
  logic [15:0] imm;
  logic [31:0] rrs, rrt_in;
  logic [4:0]  iss_dst;
  logic        iss_we, iss_load, illegal;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rf_rd_rs = rf[rf_ra_rs];
  assign rf_rd_rt = rf[rf_ra_rt];

  decode_issue #(.STALL_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .flush(flush), .rf_ra_rs(rf_ra_rs), .rf_ra_rt(rf_ra_rt), .rf_rd_rs(rf_rd_rs),
    .rf_rd_rt(rf_rd_rt), .ex_we(ex_we), .ex_dst(ex_dst), .ex_rslt(ex_rslt), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready), .iss_valid(iss_valid),
    .opcode(opcode), .funct(funct), .shamt_in(shamt_in), .imm(imm), .rrs(rrs),
    .rrt_in(rrt_in), .iss_dst(iss_dst), .iss_we(iss_we), .iss_load(iss_load),
    .illegal(illegal), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [15:0] im;
    logic [31:0] a, b;
    logic [4:0]  dst;
    logic        we, ld, ill;
  } exp_t;

  exp_t q[$];
  bit   pend[32];
  int   stalls;
  bit   m_valid;
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic void mdec(input logic [31:0] w, output bit ok, output bit urs,
                               output bit urt, output logic [4:0] d, output bit ld);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    ok = 0; urs = 0; urt = 0; d = 0; ld = 0;
    if (op == 6'h00) begin
      ok  = fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B};
      urs = ok && (fn > 6'h03);
      urt = ok;
      d   = ok ? w[15:11] : 5'd0;
    end else if (op inside {[6'h08:6'h0E], 6'h23}) begin
      ok = 1; urs = 1; d = w[20:16]; ld = (op == 6'h23);
    end else if (op == 6'h2B) begin
      ok = 1; urs = 1; urt = 1;
    end
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] s);
    if (s == 0) return 32'd0;
    if (ex_we && ex_dst == s) return ex_rslt;
    if (wb_en && wb_addr == s) return wb_data;
    return rf[s];
  endfunction

  // Called at posedge+1; drives one cycle and advances to the next posedge+1.
  task automatic step(input bit v, input logic [31:0] inst, input bit exr, input bit fl,
                      input bit exw, input logic [4:0] exd, input logic [31:0] exv,
                      input bit wbe, input logic [4:0] wba, input logic [31:0] wbd);
    bit ok, urs, urt, ld, hz, rdy, acc;
    logic [4:0] d, s, t;
    exp_t e;
    chk("stall_cnt", stall_cnt, stalls);
    if_valid = v; if_inst = inst; ex_ready = exr; flush = fl;
    ex_we = exw; ex_dst = exd; ex_rslt = exv;
    wb_en = wbe; wb_addr = wba; wb_data = wbd;
    #1;
    mdec(inst, ok, urs, urt, d, ld);
    s = inst[25:21];
    t = inst[20:16];
    hz = v && ((urs && pend[s] && !(wbe && wba == s)) ||
               (urt && pend[t] && !(wbe && wba == t)) ||
               (d != 0 && pend[d]));
    rdy = !hz && !fl && (!m_valid || exr);
    acc = v && rdy;
    chk("if_ready", if_ready, rdy);
    if (hz) stalls++;
    if (acc) begin
      e.op = inst[31:26]; e.fn = inst[5:0]; e.sh = inst[10:6]; e.im = inst[15:0];
      e.a = opnd(s); e.b = opnd(t); e.dst = d;
      e.we = ok && d != 0; e.ld = ld; e.ill = !ok;
      q.push_back(e);
    end
    if (wbe) pend[wba] = 0;
    if (acc && ld && d != 0) pend[d] = 1;
    if (fl) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (!m_valid || exr) m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit exr);
    step(0, 32'd0, exr, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, c;
    logic [5:0] fns [12];
    fns = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'h00, a, b, c, 5'($urandom), fns[$urandom_range(0, 11)]};
      3, 4:    return {6'($urandom_range(8, 14)), a, b, 16'($urandom)};
      5, 6:    return {6'h23, a, b, 16'($urandom)};
      7:       return {6'h2B, a, b, 16'($urandom)};
      8:       return {6'h3F, a, b, 16'($urandom)};
      default: return {6'h00, a, b, c, 5'd0, 6'h01};
    endcase
  endfunction

  logic        pv, pe;
  logic [5:0]  h_op, h_fn;
  logic [4:0]  h_sh, h_dst;
  logic [15:0] h_im;
  logic [31:0] h_a, h_b;
  logic        h_we, h_ld;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
      pe = 0;
    end else begin
      if (iss_valid) begin
        if (!pv || pe) begin
          if (q.size() == 0) begin
            chk("issue_expected", 0, 1);
          end else begin
            me = q.pop_front();
            chk("iss_we", iss_we, me.we);
            chk("iss_load", iss_load, me.ld);
            chk("illegal", illegal, me.ill);
            if (!me.ill) begin
              chk("opcode", opcode, me.op);
              chk("funct", funct, me.fn);
              chk("shamt_in", shamt_in, me.sh);
              chk("imm", imm, me.im);
              chk("rrs", rrs, me.a);
              chk("rrt_in", rrt_in, me.b);
              chk("iss_dst", iss_dst, me.dst);
            end
          end
        end else begin
          chk("hold_opcode", opcode, h_op);
          chk("hold_funct", funct, h_fn);
          chk("hold_shamt", shamt_in, h_sh);
          chk("hold_imm", imm, h_im);
          chk("hold_rrs", rrs, h_a);
          chk("hold_rrt", rrt_in, h_b);
          chk("hold_dst", iss_dst, h_dst);
          chk("hold_we", iss_we, h_we);
          chk("hold_load", iss_load, h_ld);
          chk("illegal_pulse", illegal, 0);
        end
      end
      pv = iss_valid; pe = ex_ready;
      h_op = opcode; h_fn = funct; h_sh = shamt_in; h_im = imm;
      h_a = rrs; h_b = rrt_in; h_dst = iss_dst; h_we = iss_we; h_ld = iss_load;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      pend[i] = 0;
    end
    stalls = 0;
    m_valid = 0;
    rst_n = 0;
    if_valid = 0; if_inst = 0; flush = 0; ex_we = 0; ex_dst = 0; ex_rslt = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_we", iss_we, 0);
    chk("rst_iss_load", iss_load, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_operands", {rrs, rrt_in}, 64'd0);
    chk("rst_fields", {opcode, funct, shamt_in, imm, iss_dst}, 64'd0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1;

    // EX forwarding with no stall
    step(1, {6'h08, 5'd0, 5'd1, 16'd5}, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(1, {6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h20}, 1, 0, 1, 5'd1, 32'd5, 0, 5'd0, 32'd0);
    // load-use stall resolved by writeback
    step(1, {6'h23, 5'd4, 5'd3, 16'd0}, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    repeat (3) step(1, {6'h00, 5'd3, 5'd3, 5'd5, 5'd0, 6'h21}, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(1, {6'h00, 5'd3, 5'd3, 5'd5, 5'd0, 6'h21}, 1, 0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h1234);
    // backpressure
    repeat (3) step(1, {6'h0D, 5'd2, 5'd6, 16'h00FF}, 0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(1, {6'h0D, 5'd2, 5'd6, 16'h00FF}, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    // register 0 destination and source
    step(1, {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 1, 0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0);
    step(1, {6'h00, 5'd0, 5'd1, 5'd4, 5'd0, 6'h20}, 1, 0, 1, 5'd0, 32'hBEEF, 1, 5'd0, 32'h77);
    // illegal then flush
    step(1, 32'hFC000000, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(1, {6'h09, 5'd1, 5'd7, 16'd9}, 1, 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle(1);
    chk("flush_iss_valid", iss_valid, 0);
    // async reset while r3 is pending
    step(1, {6'h23, 5'd4, 5'd3, 16'd8}, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(1, {6'h00, 5'd3, 5'd3, 5'd5, 5'd0, 6'h21}, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    rst_n = 0;
    if_valid = 0;
    #1;
    chk("async_rst_iss_valid", iss_valid, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    for (int i = 0; i < 32; i++) pend[i] = 0;
    stalls = 0;
    m_valid = 0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    step(1, {6'h00, 5'd3, 5'd3, 5'd5, 5'd0, 6'h21}, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 8, rand_inst(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 7)), $urandom);
    end
    repeat (4) idle(1);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage that produces the operand bundle consumed by the execute-stage ALU: opcode, rrs, rrt_in, imm, funct, shamt_in.
- Sits between instruction fetch and the ALU. Decodes the MIPS subset, reads the external register file, and forwards results from EX and WB.
- Interlocks on load-use and WAW hazards using a per-register scoreboard, and holds its output register under downstream backpressure.

Parameters:
- STALL_CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- if_valid  in  1  fetch presents an instruction.
- if_inst  in  32  instruction word.
- if_ready  out  1  instruction accepted on the clock edge when if_valid&&if_ready.
- flush  in  1  synchronous kill of the issue register and the current fetch word.
- rf_ra_rs  out  5  register file read address, rs = if_inst[25:21].
- rf_ra_rt  out  5  register file read address, rt = if_inst[20:16].
- rf_rd_rs  in  32  register file read data for rs (combinational).
- rf_rd_rt  in  32  register file read data for rt (combinational).
- ex_we  in  1  the ALU output currently holds a register-writing result.
- ex_dst  in  5  destination register of that ALU result.
- ex_rslt  in  32  ALU result.
- wb_en  in  1  writeback port writes this cycle.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- ex_ready  in  1  execute stage accepts the issue register.
- iss_valid  out  1  issue register holds a valid operation.
- opcode  out  6  to ALU.
- funct  out  6  to ALU.
- shamt_in  out  5  to ALU.
- imm  out  16  to ALU.
- rrs  out  32  rs operand, after forwarding.
- rrt_in  out  32  rt operand, after forwarding; also the SW store data.
- iss_dst  out  5  destination register.
- iss_we  out  1  operation writes iss_dst.
- iss_load  out  1  operation is LW.
- illegal  out  1  one-cycle pulse when an unsupported instruction is accepted.
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - iss_valid=0, iss_we=0, iss_load=0, illegal=0.
  - opcode, funct, shamt_in, imm, rrs, rrt_in and iss_dst all 0.
  - Scoreboard cleared, stall_cnt=0.
- Supported opcodes: R=0x00, ADDI=0x08, ADDIU=0x09, SLTI=0x0A, SLTIU=0x0B, ANDI=0x0C, ORI=0x0D, XORI=0x0E, LW=0x23, SW=0x2B.
- Supported R-type functs: SLL=0x00, SRL=0x02, SRA=0x03, ADD..NOR=0x20..0x27, SLT=0x2A, SLTU=0x2B.
- Source register usage:
  - R-type shifts use rt only.
  - Other R-type use rs and rt.
  - I-type ALU ops and LW use rs only.
  - SW uses rs and rt.
- Destination:
  - R-type writes rd.
  - I-type ALU ops and LW write rt.
  - SW writes nothing.
  - iss_we=0 whenever the destination is register 0.
- Unsupported opcode or funct: the instruction issues as a bubble (iss_valid=1, iss_we=0, iss_load=0) and illegal pulses for one cycle.
- Operand select, per source register s, highest priority first:
  1. s==0 gives 0.
  2. ex_we && ex_dst==s gives ex_rslt.
  3. wb_en && wb_addr==s gives wb_data.
  4. Otherwise the register file read data.
- Scoreboard:
  - 32 pending bits.
  - The bit for iss_dst is set on the edge that accepts an LW.
  - A bit is cleared on the edge where wb_en && wb_addr matches it.
  - If set and clear hit the same register on the same edge, set wins.
- hazard = if_valid && any of:
  - a used source is pending and is not being supplied by wb on this cycle;
  - the destination is pending (WAW).
- Issue-register handshake:
  - if_ready = !hazard && !flush && (!iss_valid || ex_ready).
  - On accept: the issue register loads the decoded instruction with latency 1.
  - Hold: if iss_valid && !ex_ready, every output is held stable.
  - Drain: if the issue register empties with no accept, iss_valid goes to 0.
- Flush: on the next edge iss_valid=0 and the fetch word is not accepted. Scoreboard contents are kept, because in-flight loads still complete. Flush overrides hold.
- stall_cnt increments on every cycle where hazard is high, and saturates at all-ones.
- States: RUN (normal issue), HAZ (hazard high; issue register drains or holds), HOLD (output held under backpressure). The state is derived from hazard and ex_ready; no separate encoding is required.

Decomposition:
- Shared constants package INST: all opcode and funct codes listed above, shared with the ALU.
- Sub-module decode_issue_fwd: the combinational 3-way forwarding mux, instantiated once for rs and once for rt.

Test Plan:
1. Forwarding from EX: issue ADDI r1,r0,5, then ADD r2,r1,r1 on the next cycle with ex_we=1, ex_dst=1, ex_rslt=5 → second issue has rrs=5, rrt_in=5, and if_ready never deasserts.
2. Load-use stall: LW r3,0(r4), then ADDU r5,r3,r3 → if_ready=0 until wb_en=1, wb_addr=3, wb_data=0x1234. The ADDU issues on that edge with rrs=0x1234, and stall_cnt counts the waited cycles.
3. Backpressure: ex_ready=0 for 3 cycles with iss_valid=1 → all outputs held stable and if_ready=0. They release on the cycle ex_ready=1.
4. Register 0: ADD r0,r1,r2 with ex_dst=0 and ex_we=1 → iss_we=0. A following source read of r0 yields 0, not ex_rslt.
5. Illegal and flush: if_inst=0xFC000000 → one-cycle illegal pulse, bubble issued. Assert flush with if_valid=1 → iss_valid=0 on the next edge and the instruction is not accepted.
6. Async reset mid-stall: drop rst_n while the scoreboard has r3 pending → iss_valid=0 immediately, the scoreboard is cleared, and the following ADDU r5,r3,r3 issues without stalling.
